// File: rtl/event_encoder_4to2_pkg.sv
// event_encoder_pkg: shared constants and types for the event encoder.
//   N_DEF / IDX_W_DEF : default number of sources and index width.
//   state_e           : output-stage state (EMPTY / FULL).
//   clog2()           : constant ceil(log2) helper for parameter checks.
// Optional feature macro used by the encoder: EVENT_ENCODER_ROUND_ROBIN_EN.
package event_encoder_pkg;

    localparam int N_DEF     = 4;
    localparam int IDX_W_DEF = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/event_encoder_4to2_if.sv
// event_encoder_4to2_if: event input and encoded-index output bundle.
//   en, in            : capture enable and N event pulses (into the encoder).
//   out_valid/out_idx : presented event and its binary index.
//   out_ready         : consumer accepts the presented event.
//   busy, overflow    : status outputs.
// master = encoder side, slave = source/consumer side.
interface event_encoder_4to2_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic             en;
    logic [N-1:0]     in;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    logic             overflow;

    modport master (
        input  en, in, out_ready,
        output out_valid, out_idx, busy, overflow
    );

    modport slave (
        output en, in, out_ready,
        input  out_valid, out_idx, busy, overflow
    );
endinterface

// File: rtl/event_encoder_4to2_prio_pick.sv
// prio_pick: combinational priority picker with a rotating start point.
//   req  : request vector (N bits).
//   base : index where the search starts; wraps modulo N (tie to 0 for fixed).
//   found: at least one request set.
//   idx  : first set index at or after base (wrapping).
//   mask : one-hot of idx, all zero when nothing is found.
// N must be a power of two so that IDX_W-bit addition wraps modulo N.
module prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     mask
);

    always_comb begin
        logic [IDX_W-1:0] pos;
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = base + k[IDX_W-1:0];
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign mask[gi] = found && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/event_encoder_4to2.sv
// event_encoder_4to2: collects event pulses from N sources into a pending
// register and emits them one per transfer as a binary index over a
// valid/ready handshake.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : event_encoder_4to2_if.master (en, in, out_ready in;
//              out_valid, out_idx, busy, overflow out).
// Optional feature: define EVENT_ENCODER_ROUND_ROBIN_EN for rotating
// priority (search starts after the last pick); otherwise lowest index wins.
// IDX_W must equal clog2(N) and N must be a power of two.
module event_encoder_4to2
    import event_encoder_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    event_encoder_4to2_if.master bus
);

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     pick_mask_raw;
    logic [N-1:0]     pick_mask;
    logic [N-1:0]     in_gated;
    logic [N-1:0]     merge_hit;
    logic [IDX_W-1:0] pick_base;
    logic             load_slot;

    // The output slot can take a new pick when it is empty or when the
    // current event is being accepted this cycle.
    assign load_slot = (state_q == ST_EMPTY) || bus.out_ready;
    assign in_gated  = bus.en ? bus.in : '0;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign pick_base = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (load_slot && pick_found) begin
            ptr_d = pick_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign pick_base = '0;
`endif

    prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_pick (
        .req   (pending_q),
        .base  (pick_base),
        .found (pick_found),
        .idx   (pick_idx),
        .mask  (pick_mask_raw)
    );

    // A pick only takes effect when the slot can accept it.
    assign pick_mask = load_slot ? pick_mask_raw : '0;

    // An arriving event on a bit that stays pending is merged and flagged;
    // a bit being picked this cycle re-arms cleanly instead.
    for (genvar gi = 0; gi < N; gi++) begin : g_merge
        assign merge_hit[gi] = in_gated[gi] & pending_q[gi] & ~pick_mask[gi];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = (pending_q & ~pick_mask) | in_gated;
        overflow_d = overflow_q | (|merge_hit);
        if (load_slot) begin
            if (pick_found) begin
                state_d = ST_FULL;
                idx_d   = pick_idx;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            pending_q  <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_idx   = idx_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (|pending_q) || (state_q == ST_FULL);

endmodule

// File: tb/tb_event_encoder_4to2.sv
// tb_event_encoder_4to2: directed scenarios with literal expectations, then
// randomized traffic; every cycle the DUT is compared with a behavioural
// model of the pending set and the single-entry output slot.
module tb_event_encoder_4to2;

    logic clk;
    logic rst;

    event_encoder_4to2_if #(.N(4), .IDX_W(2)) bus ();

    event_encoder_4to2 #(.N(4), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model state
    bit m_pend[4];
    bit m_valid;
    int m_idx;
    bit m_ovf;
    int m_ptr;

    int dut_x[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input logic [3:0] i, input bit rdy);
        int  p;
        bit  slot;
        if (r) begin
            for (int j = 0; j < 4; j++) m_pend[j] = 1'b0;
            m_valid = 1'b0;
            m_idx   = 0;
            m_ovf   = 1'b0;
            m_ptr   = 0;
            return;
        end
        p    = -1;
        slot = !m_valid || rdy;
        if (slot) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (p < 0 && m_pend[j]) p = j;
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (e && i[j] && m_pend[j] && j != p) m_ovf = 1'b1;
        end
        for (int j = 0; j < 4; j++) begin
            if (j == p) m_pend[j] = 1'b0;
            if (e && i[j]) m_pend[j] = 1'b1;
        end
        if (slot) begin
            if (p >= 0) begin
                m_valid = 1'b1;
                m_idx   = p;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
                m_ptr   = (p + 1) % 4;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    function automatic bit m_busy();
        bit b;
        b = m_valid;
        for (int j = 0; j < 4; j++) b = b | m_pend[j];
        return b;
    endfunction

    // One clock: drive at negedge, model steps with the DUT at posedge,
    // outputs are compared at the following negedge.
    task automatic cycle(input bit r, input bit e, input logic [3:0] i, input bit rdy);
        rst           = r;
        bus.en        = e;
        bus.in        = i;
        bus.out_ready = rdy;
        #1;
        if (!r && bus.out_valid && rdy) begin
            dut_x.push_back(int'(bus.out_idx));
            $display("xfer cycle=%0d idx=%0d", cyc, bus.out_idx);
        end
        @(posedge clk);
        model_step(r, e, i, rdy);
        @(negedge clk);
        cyc++;
        chk("out_valid", int'(bus.out_valid), int'(m_valid));
        chk("busy", int'(bus.busy), int'(m_busy()));
        chk("overflow", int'(bus.overflow), int'(m_ovf));
        if (m_valid) chk("out_idx", int'(bus.out_idx), m_idx);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 4'b0000, 1'b0);
        dut_x.delete();
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        model_step(1'b1, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);

        // Reset dominates active inputs
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, 4'b1111, 1'b1);
            chk("rst_valid", int'(bus.out_valid), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_ovf", int'(bus.overflow), 0);
        end
        cycle(1'b0, 1'b1, 4'b0000, 1'b0);
        chk("rst_pending_empty", int'(bus.busy), 0);

        // Single event: visible two cycles after it arrives, for one cycle
        do_reset();
        cycle(1'b0, 1'b1, 4'b0100, 1'b1);
        chk("single_t1_valid", int'(bus.out_valid), 0);
        chk("single_t1_busy", int'(bus.busy), 1);
        cycle(1'b0, 1'b1, 4'b0000, 1'b1);
        chk("single_t2_valid", int'(bus.out_valid), 1);
        chk("single_t2_idx", int'(bus.out_idx), 2);
        cycle(1'b0, 1'b1, 4'b0000, 1'b1);
        chk("single_t3_valid", int'(bus.out_valid), 0);
        chk("single_t3_busy", int'(bus.busy), 0);

        // Multi-hot, back-to-back drain in priority order
        do_reset();
        cycle(1'b0, 1'b1, 4'b1011, 1'b1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 4'b0000, 1'b1);
        chk("multi_end_valid", int'(bus.out_valid), 0);
        chk("multi_count", dut_x.size(), 3);
        if (dut_x.size() == 3) begin
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
            // pointer starts at 0 after reset, so the first pass matches fixed order
`endif
            chk("multi_x0", dut_x[0], 0);
            chk("multi_x1", dut_x[1], 1);
            chk("multi_x2", dut_x[2], 3);
        end

        // Backpressure: head held stable while out_ready is low
        do_reset();
        cycle(1'b0, 1'b1, 4'b0110, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 4'b0000, 1'b0);
            chk("bp_hold_idx", int'(bus.out_idx), 1);
            chk("bp_hold_valid", int'(bus.out_valid), 1);
        end
        cycle(1'b0, 1'b1, 4'b0000, 1'b1);
        cycle(1'b0, 1'b1, 4'b0000, 1'b1);
        chk("bp_count", dut_x.size(), 2);
        if (dut_x.size() == 2) begin
            chk("bp_x0", dut_x[0], 1);
            chk("bp_x1", dut_x[1], 2);
        end
        chk("bp_ovf", int'(bus.overflow), 0);

        // Overflow/merge: bit 3 re-arrives while still pending behind a held event
        do_reset();
        cycle(1'b0, 1'b1, 4'b0001, 1'b0);
        cycle(1'b0, 1'b1, 4'b1000, 1'b0);
        cycle(1'b0, 1'b1, 4'b0000, 1'b0);
        chk("ovf_before", int'(bus.overflow), 0);
        cycle(1'b0, 1'b1, 4'b1000, 1'b0);
        chk("ovf_after", int'(bus.overflow), 1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 4'b0000, 1'b1);
        chk("ovf_sticky", int'(bus.overflow), 1);
        chk("ovf_count", dut_x.size(), 2);
        begin
            int n3;
            n3 = 0;
            foreach (dut_x[k]) if (dut_x[k] == 3) n3++;
            chk("ovf_idx3_once", n3, 1);
        end

        // en low: inputs ignored, pending still drains
        do_reset();
        cycle(1'b0, 1'b1, 4'b0101, 1'b0);
        cycle(1'b0, 1'b0, 4'b1010, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 4'b1111, 1'b1);
        chk("en_low_count", dut_x.size(), 2);
        chk("en_low_busy", int'(bus.busy), 0);

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        // Rotating priority alternates between the two held sources
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 4'b0011, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 4'b0011, 1'b1);
        chk("rr_count", dut_x.size(), 5);
        if (dut_x.size() == 5) begin
            chk("rr_x0", dut_x[0], 0);
            chk("rr_x1", dut_x[1], 1);
            chk("rr_x2", dut_x[2], 0);
            chk("rr_x3", dut_x[3], 1);
            chk("rr_x4", dut_x[4], 0);
        end
`endif

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            bit         r;
            bit         e;
            bit         rdy;
            logic [3:0] i;
            r   = ($urandom_range(0, 299) == 0);
            e   = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            i   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            cycle(r, e, i, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
